// File: rtl/stream_demux.sv
// stream_demux: steers one valid/ready stream into per-channel one-deep holding registers by select;
// words with an out-of-range select are consumed, dropped and counted (saturating).
module stream_demux #(
    parameter int N_CH  = 3,
    parameter int W     = 8,
    parameter int SEL_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                up_valid,
    output logic                up_ready,
    input  logic [W-1:0]        up_data,
    input  logic [SEL_W-1:0]    up_sel,
    output logic [N_CH-1:0]     dn_valid,
    input  logic [N_CH-1:0]     dn_ready,
    output logic [N_CH*W-1:0]   dn_data,
    output logic [7:0]          drop_cnt,
    output logic                busy
);
    logic [N_CH-1:0]   r_valid;
    logic [N_CH*W-1:0] r_data;
    logic [7:0]        r_drop;
    logic [N_CH-1:0]   w_hit;
    logic [N_CH-1:0]   w_load;
    logic              w_accept;

    // one-hot decode; an out-of-range select hits nothing, so it is always ready
    for (genvar k = 0; k < N_CH; k++) begin : g_hit
        assign w_hit[k] = (up_sel == SEL_W'(k));
    end

    assign up_ready = ~|(w_hit & r_valid & ~dn_ready);
    assign w_accept = up_valid & up_ready;
    assign w_load   = w_hit & {N_CH{w_accept}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_data  <= '0;
            r_drop  <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (w_load[k]) begin
                    r_valid[k]         <= 1'b1;
                    r_data[k*W +: W]   <= up_data;
                end else if (dn_ready[k]) begin
                    r_valid[k]         <= 1'b0;
                end
            end
            if (w_accept && w_hit == '0 && r_drop != 8'hFF)
                r_drop <= r_drop + 8'd1;
        end
    end

    assign dn_valid = r_valid;
    assign dn_data  = r_data;
    assign drop_cnt = r_drop;
    assign busy     = |r_valid;
endmodule
